nn_rv_loader: RTL and testbench

Serial boot loader for the nnRv SoC. Receives a framed program image over a UART RX line, writes it word-by-word into the instruction/data RAM from address 0, and holds the CPU in reset until a complete image with a valid checksum has been written. It is the writer end of the RAM the CPU fetches from, and sits between the board UART pin and the RAM write port and CPU reset.

---
 rtl/nn_rv_loader_pkg.sv | 29 ++
 rtl/nn_uart_rx.sv | 94 +++++++++
 rtl/nn_rv_loader.sv | 136 +++++++++++++
 tb/tb_nn_rv_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_rv_loader_pkg.sv
// Shared definitions for the nnRv serial boot loader: sync byte, loader and
// receiver state encodings, and a helper classifying in-frame states.
package nn_rv_loader_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN_L = 3'd1,
        S_LEN_H = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // States where framing errors and inter-byte timeouts abort the frame.
    function automatic logic in_frame(loader_state_t s);
        return (s == S_LEN_L) || (s == S_LEN_H) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/nn_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, glitch
// rejection on the start bit and a framing-error pulse on a low stop bit.
module nn_uart_rx
    import nn_rv_loader_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output rx_state_t  dbg_state
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    rx_state_t        state;

    assign dbg_state = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            state      <= RX_IDLE;
        end else begin
            rx_meta    <= rxd;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        cnt   <= '0;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_W'(DIV - 1)) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_W'(DIV - 1)) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/nn_rv_loader.sv
// Serial boot loader: parses A5/LEN/DATA/CSUM frames from the UART, writes
// words into RAM from address 0 and releases CPU reset on a valid image.
module nn_rv_loader
    import nn_rv_loader_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int RAM_WORDS   = 1024,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 16 * (CLK_HZ / BAUD) * 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              UART_RXD,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_WADDR,
    output logic [31:0]       RAM_WDATA,
    output logic              CPU_RST_N,
    output logic              LOAD_BUSY,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR,
    output loader_state_t     DBG_STATE,
    output rx_state_t         DBG_RX_STATE
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [7:0]        rx_byte;
    logic              rx_valid, rx_ferr;
    loader_state_t     state;
    logic [15:0]       len_r, len_word;
    logic [7:0]        csum;
    logic [23:0]       word_r;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] idx;
    logic [TMO_W-1:0]  tmo;

    nn_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .rxd        (UART_RXD),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr),
        .dbg_state  (DBG_RX_STATE)
    );

    assign len_word  = {rx_byte, len_r[7:0]};
    assign DBG_STATE = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            RAM_WE    <= 1'b0;
            RAM_WADDR <= '0;
            RAM_WDATA <= '0;
            CPU_RST_N <= 1'b0;
            LOAD_BUSY <= 1'b0;
            LOAD_DONE <= 1'b0;
            LOAD_ERR  <= 1'b0;
            len_r     <= '0;
            csum      <= '0;
            word_r    <= '0;
            byte_cnt  <= '0;
            idx       <= '0;
            tmo       <= '0;
        end else begin
            RAM_WE <= 1'b0;
            tmo    <= (in_frame(state) && !rx_valid) ? tmo + 1'b1 : '0;
            // A received byte takes priority over a coincident timeout.
            if (rx_valid) begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (rx_byte == LOADER_SYNC) begin
                            state     <= S_LEN_L;
                            CPU_RST_N <= 1'b0;
                            LOAD_BUSY <= 1'b1;
                            LOAD_DONE <= 1'b0;
                            LOAD_ERR  <= 1'b0;
                            idx       <= '0;
                            csum      <= '0;
                        end
                    end
                    S_LEN_L: begin
                        len_r <= {8'h00, rx_byte};
                        csum  <= csum ^ rx_byte;
                        state <= S_LEN_H;
                    end
                    S_LEN_H: begin
                        len_r    <= len_word;
                        csum     <= csum ^ rx_byte;
                        byte_cnt <= '0;
                        if (len_word > 16'(RAM_WORDS)) begin
                            state     <= S_ERR;
                            LOAD_ERR  <= 1'b1;
                            LOAD_BUSY <= 1'b0;
                        end else if (len_word == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        csum     <= csum ^ rx_byte;
                        word_r   <= {rx_byte, word_r[23:8]};
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            RAM_WE    <= 1'b1;
                            RAM_WDATA <= {rx_byte, word_r};
                            RAM_WADDR <= idx;
                            idx       <= idx + 1'b1;
                            if (16'(idx) + 16'd1 == len_r) state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        LOAD_BUSY <= 1'b0;
                        if (rx_byte == csum) begin
                            state     <= S_DONE;
                            CPU_RST_N <= 1'b1;
                            LOAD_DONE <= 1'b1;
                        end else begin
                            state     <= S_ERR;
                            LOAD_ERR  <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (in_frame(state) && (rx_ferr || tmo == TMO_W'(TIMEOUT_CYC))) begin
                state     <= S_ERR;
                LOAD_ERR  <= 1'b1;
                LOAD_BUSY <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nn_rv_loader.sv
// Bench for nn_rv_loader: drives UART frames and checks RAM writes and
// loader status against a frame-level reference model.
module tb_nn_rv_loader;
    import nn_rv_loader_pkg::*;

    localparam int CLK_HZ    = 1_000_000;
    localparam int BAUD      = 100_000;
    localparam int RAM_WORDS = 16;
    localparam int ADDR_W    = 4;
    localparam int DIV       = CLK_HZ / BAUD;
    localparam int CLK_P     = 10;
    localparam int BIT_T     = DIV * CLK_P;
    localparam int TIMEOUT   = 16 * DIV * 10;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              UART_RXD = 1'b1;
    logic              RAM_WE;
    logic [ADDR_W-1:0] RAM_WADDR;
    logic [31:0]       RAM_WDATA;
    logic              CPU_RST_N, LOAD_BUSY, LOAD_DONE, LOAD_ERR;
    loader_state_t     DBG_STATE;
    rx_state_t         DBG_RX_STATE;

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;
    logic prev_we = 1'b0;
    logic [31:0] mem [RAM_WORDS];
    logic [31:0] word_q [$];
    logic [7:0]  frame_q [$];

    nn_rv_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .RAM_WORDS(RAM_WORDS), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .UART_RXD(UART_RXD),
        .RAM_WE(RAM_WE), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA),
        .CPU_RST_N(CPU_RST_N), .LOAD_BUSY(LOAD_BUSY), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR),
        .DBG_STATE(DBG_STATE), .DBG_RX_STATE(DBG_RX_STATE)
    );

    // Clock / reset
    always #(CLK_P / 2) CLK = ~CLK;

    // RAM model fed by the write port; every strobe is checked for range and width.
    always @(negedge CLK) begin
        if (RAM_WE) begin
            n_cmp++;
            if (int'(RAM_WADDR) >= RAM_WORDS || prev_we) begin
                n_err++;
                $display("FAIL ram_we_strobe: addr=%0d repeated=%0b, required addr<%0d single-cycle",
                         RAM_WADDR, prev_we, RAM_WORDS);
            end
            mem[RAM_WADDR] = RAM_WDATA;
            we_cnt++;
        end
        prev_we = RAM_WE;
    end

    // Drivers
    task automatic send_byte_stop(input logic [7:0] b, input logic stop);
        UART_RXD = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            UART_RXD = b[i];
            #(BIT_T);
        end
        UART_RXD = stop;
        #(BIT_T);
        UART_RXD = 1'b1;
        #(BIT_T);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_byte_stop(b, 1'b1);
    endtask

    // Reference frame: sync, LE length, LE words, XOR checksum (optionally corrupted).
    task automatic build_frame(input logic [15:0] n, input bit flip, input bit hdr_only);
        logic [7:0] cs;
        frame_q = {};
        frame_q.push_back(8'hA5);
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        if (hdr_only) return;
        cs = n[7:0] ^ n[15:8];
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < 4; k++) begin
                frame_q.push_back(word_q[i][8*k +: 8]);
                cs ^= word_q[i][8*k +: 8];
            end
        end
        frame_q.push_back(flip ? ~cs : cs);
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i]);
        repeat (3) @(negedge CLK);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < RAM_WORDS; i++) mem[i] = 'x;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        UART_RXD = 1'b1;
        repeat (4) @(negedge CLK);
        n_cmp++; if (RAM_WE !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0b want 0", RAM_WE); end
        n_cmp++; if (RAM_WADDR !== '0) begin n_err++; $display("FAIL reset_waddr: got %0d want 0", RAM_WADDR); end
        n_cmp++; if (RAM_WDATA !== '0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", RAM_WDATA); end
        n_cmp++; if (CPU_RST_N !== 1'b0) begin n_err++; $display("FAIL reset_cpu_rst_n: got %0b want 0", CPU_RST_N); end
        n_cmp++; if (LOAD_BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", LOAD_BUSY); end
        n_cmp++; if (LOAD_DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", LOAD_DONE); end
        n_cmp++; if (LOAD_ERR !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b want 0", LOAD_ERR); end
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        n_cmp++; if (DBG_STATE !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", DBG_STATE, S_IDLE); end
    endtask

    task automatic test_basic_frame();
        int we0 = we_cnt;
        clear_mem();
        word_q = {32'h12345678, 32'hDEADBEEF};
        build_frame(16'd2, 1'b0, 1'b0);
        send_frame();
        n_cmp++; if (mem[0] !== 32'h12345678) begin n_err++; $display("FAIL basic_ram0: got %h want 12345678", mem[0]); end
        n_cmp++; if (mem[1] !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_ram1: got %h want deadbeef", mem[1]); end
        n_cmp++; if (we_cnt - we0 != 2) begin n_err++; $display("FAIL basic_we_count: got %0d want 2", we_cnt - we0); end
        n_cmp++; if (CPU_RST_N !== 1'b1) begin n_err++; $display("FAIL basic_cpu_rst_n: got %0b want 1", CPU_RST_N); end
        n_cmp++; if (LOAD_DONE !== 1'b1 || LOAD_ERR !== 1'b0 || LOAD_BUSY !== 1'b0) begin
            n_err++; $display("FAIL basic_status: got done=%0b err=%0b busy=%0b want 1/0/0", LOAD_DONE, LOAD_ERR, LOAD_BUSY);
        end
    endtask

    task automatic test_bad_csum();
        int we0 = we_cnt;
        clear_mem();
        word_q = {32'h12345678, 32'hDEADBEEF};
        build_frame(16'd2, 1'b1, 1'b0);
        send_frame();
        n_cmp++; if (mem[0] !== 32'h12345678 || mem[1] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL badcs_ram: got %h %h want 12345678 deadbeef", mem[0], mem[1]);
        end
        n_cmp++; if (we_cnt - we0 != 2) begin n_err++; $display("FAIL badcs_we_count: got %0d want 2", we_cnt - we0); end
        n_cmp++; if (LOAD_ERR !== 1'b1 || LOAD_DONE !== 1'b0 || CPU_RST_N !== 1'b0) begin
            n_err++; $display("FAIL badcs_status: got err=%0b done=%0b cpu=%0b want 1/0/0", LOAD_ERR, LOAD_DONE, CPU_RST_N);
        end
        build_frame(16'd2, 1'b0, 1'b0);
        send_frame();
        n_cmp++; if (LOAD_DONE !== 1'b1 || LOAD_ERR !== 1'b0 || CPU_RST_N !== 1'b1) begin
            n_err++; $display("FAIL badcs_recover: got done=%0b err=%0b cpu=%0b want 1/0/1", LOAD_DONE, LOAD_ERR, CPU_RST_N);
        end
    endtask

    task automatic test_len_too_big();
        int we0 = we_cnt;
        build_frame(16'h0011, 1'b0, 1'b1);
        send_frame();
        n_cmp++; if (DBG_STATE !== S_ERR || LOAD_ERR !== 1'b1 || LOAD_BUSY !== 1'b0) begin
            n_err++; $display("FAIL biglen_status: got state=%0d err=%0b busy=%0b want %0d/1/0", DBG_STATE, LOAD_ERR, LOAD_BUSY, S_ERR);
        end
        n_cmp++; if (CPU_RST_N !== 1'b0) begin n_err++; $display("FAIL biglen_cpu_rst_n: got %0b want 0", CPU_RST_N); end
        n_cmp++; if (we_cnt != we0) begin n_err++; $display("FAIL biglen_we_count: got %0d want 0", we_cnt - we0); end
    endtask

    task automatic test_glitch_and_ferr();
        int we0;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        we0 = we_cnt;
        UART_RXD = 1'b0;
        repeat (3) @(negedge CLK);
        UART_RXD = 1'b1;
        repeat (3 * DIV) @(negedge CLK);
        n_cmp++; if (DBG_STATE !== S_IDLE) begin n_err++; $display("FAIL glitch_state: got %0d want %0d", DBG_STATE, S_IDLE); end
        send_byte_stop(8'h00, 1'b0);
        send_byte(8'h55);
        repeat (3) @(negedge CLK);
        n_cmp++; if (DBG_STATE !== S_IDLE) begin n_err++; $display("FAIL noise_state: got %0d want %0d", DBG_STATE, S_IDLE); end
        n_cmp++; if (CPU_RST_N !== 1'b0 || LOAD_BUSY !== 1'b0 || LOAD_DONE !== 1'b0 || LOAD_ERR !== 1'b0) begin
            n_err++; $display("FAIL noise_status: got cpu=%0b busy=%0b done=%0b err=%0b want 0/0/0/0", CPU_RST_N, LOAD_BUSY, LOAD_DONE, LOAD_ERR);
        end
        n_cmp++; if (we_cnt != we0 || RAM_WADDR !== '0 || RAM_WDATA !== '0) begin
            n_err++; $display("FAIL noise_ram: got writes=%0d addr=%0d data=%h want 0/0/0", we_cnt - we0, RAM_WADDR, RAM_WDATA);
        end
    endtask

    task automatic test_timeout_and_reset();
        int we0 = we_cnt;
        word_q = {32'h11223344, 32'h55667788};
        build_frame(16'd2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(frame_q[i]);
        repeat (TIMEOUT - 200) @(negedge CLK);
        n_cmp++; if (LOAD_BUSY !== 1'b1 || LOAD_ERR !== 1'b0) begin
            n_err++; $display("FAIL tmo_early: got busy=%0b err=%0b want 1/0", LOAD_BUSY, LOAD_ERR);
        end
        repeat (300) @(negedge CLK);
        n_cmp++; if (LOAD_ERR !== 1'b1 || LOAD_BUSY !== 1'b0 || DBG_STATE !== S_ERR) begin
            n_err++; $display("FAIL tmo_expired: got err=%0b busy=%0b state=%0d want 1/0/%0d", LOAD_ERR, LOAD_BUSY, DBG_STATE, S_ERR);
        end
        n_cmp++; if (we_cnt != we0) begin n_err++; $display("FAIL tmo_we_count: got %0d want 0", we_cnt - we0); end
        // Abort with three data bytes of a word in and the fourth arriving.
        for (int i = 0; i < 6; i++) send_byte(frame_q[i]);
        UART_RXD = 1'b0;
        #(3 * BIT_T);
        @(negedge CLK);
        n_cmp++; if (LOAD_BUSY !== 1'b1) begin n_err++; $display("FAIL midframe_busy: got %0b want 1", LOAD_BUSY); end
        #2;
        RST_N = 1'b0;
        #1;
        n_cmp++; if (RAM_WE !== 1'b0 || RAM_WADDR !== '0 || RAM_WDATA !== '0 || CPU_RST_N !== 1'b0 ||
                     LOAD_BUSY !== 1'b0 || LOAD_DONE !== 1'b0 || LOAD_ERR !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got we=%0b addr=%0d data=%h cpu=%0b busy=%0b done=%0b err=%0b want all 0",
                              RAM_WE, RAM_WADDR, RAM_WDATA, CPU_RST_N, LOAD_BUSY, LOAD_DONE, LOAD_ERR);
        end
        UART_RXD = 1'b1;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2 * DIV) @(negedge CLK);
        n_cmp++; if (we_cnt != we0 || DBG_STATE !== S_IDLE) begin
            n_err++; $display("FAIL post_reset: got writes=%0d state=%0d want 0/%0d", we_cnt - we0, DBG_STATE, S_IDLE);
        end
    endtask

    task automatic test_restart_in_done();
        int we0;
        word_q = {32'hCAFEF00D};
        build_frame(16'd1, 1'b0, 1'b0);
        send_frame();
        n_cmp++; if (LOAD_DONE !== 1'b1 || CPU_RST_N !== 1'b1) begin
            n_err++; $display("FAIL restart_pre: got done=%0b cpu=%0b want 1/1", LOAD_DONE, CPU_RST_N);
        end
        we0 = we_cnt;
        send_byte(8'hA5);
        n_cmp++; if (CPU_RST_N !== 1'b0 || LOAD_BUSY !== 1'b1 || LOAD_DONE !== 1'b0) begin
            n_err++; $display("FAIL restart_sync: got cpu=%0b busy=%0b done=%0b want 0/1/0", CPU_RST_N, LOAD_BUSY, LOAD_DONE);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (3) @(negedge CLK);
        n_cmp++; if (LOAD_DONE !== 1'b1 || CPU_RST_N !== 1'b1 || LOAD_ERR !== 1'b0 || we_cnt != we0) begin
            n_err++; $display("FAIL zero_len: got done=%0b cpu=%0b err=%0b writes=%0d want 1/1/0/0",
                              LOAD_DONE, CPU_RST_N, LOAD_ERR, we_cnt - we0);
        end
    endtask

    // Random frames, including a full-depth image and oversize/corrupt cases.
    task automatic test_random_frames();
        for (int it = 0; it < 7; it++) begin
            int n, mode, we0, exp_writes;
            bit flip, hdr_only, exp_done;
            mode = (it == 0) ? 3 : $urandom_range(0, 3);
            n = (it == 0) ? RAM_WORDS : $urandom_range(1, 8);
            flip = (mode == 0);
            hdr_only = (mode == 1);
            if (hdr_only) n = $urandom_range(RAM_WORDS + 1, 300);
            word_q = {};
            for (int i = 0; i < n; i++) word_q.push_back($urandom());
            exp_writes = hdr_only ? 0 : n;
            exp_done = !hdr_only && !flip;
            clear_mem();
            we0 = we_cnt;
            build_frame(16'(n), flip, hdr_only);
            send_frame();
            for (int i = 0; i < exp_writes; i++) begin
                n_cmp++; if (mem[i] !== word_q[i]) begin
                    n_err++; $display("FAIL rand_ram[%0d] it=%0d: got %h want %h", i, it, mem[i], word_q[i]);
                end
            end
            n_cmp++; if (we_cnt - we0 != exp_writes) begin
                n_err++; $display("FAIL rand_we_count it=%0d: got %0d want %0d", it, we_cnt - we0, exp_writes);
            end
            n_cmp++; if (LOAD_DONE !== exp_done || LOAD_ERR !== !exp_done || CPU_RST_N !== exp_done || LOAD_BUSY !== 1'b0) begin
                n_err++; $display("FAIL rand_status it=%0d: got done=%0b err=%0b cpu=%0b busy=%0b want %0b/%0b/%0b/0",
                                  it, LOAD_DONE, LOAD_ERR, CPU_RST_N, LOAD_BUSY, exp_done, !exp_done, exp_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_bad_csum();
        test_len_too_big();
        test_glitch_and_ferr();
        test_timeout_and_reset();
        test_restart_in_done();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
